frame_writer: RTL and testbench



---
 rtl/fw_pkg.sv | 32 +++
 rtl/fw_beat_reg.sv | 41 ++++
 rtl/frame_writer.sv | 155 +++++++++++++++
 tb/tb_frame_writer.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fw_pkg.sv
`default_nettype none
// ============================================================================
// Package  : fw_pkg -- shared state encoding and sizing helpers for frame_writer
// Revision : 1.0
// ============================================================================
package fw_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WAIT  = 3'd1,
        POP   = 3'd2,
        FETCH = 3'd3,
        WRITE = 3'd4
    } fw_state_t;

    // FRAME_PIX for a given geometry.
    function automatic int unsigned fw_frame_pix(input int unsigned h_res,
                                                 input int unsigned v_res);
        return h_res * v_res;
    endfunction

    // Words to gather before a burst: a full burst, or whatever the frame still lacks.
    function automatic int unsigned fw_need(input int unsigned burst_len,
                                            input int unsigned frame_pix,
                                            input int unsigned pix_idx);
        int unsigned remain;
        remain = frame_pix - pix_idx;
        return (burst_len < remain) ? burst_len : remain;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fw_beat_reg.sv
`default_nettype none
// ============================================================================
// Module   : fw_beat_reg -- valid/ready output register for one memory write beat
// Revision : 1.0
// ============================================================================
module fw_beat_reg #(
    parameter int DATA_W = 16
) (
    input  logic              clk_100,
    input  logic              rst,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_load_data,
    input  logic              i_flush,
    input  logic              i_ready,
    output logic              o_req,
    output logic [DATA_W-1:0] o_data
);

    logic              r_req;
    logic [DATA_W-1:0] r_data;

    // Flush beats load so an abort never leaves a stale request behind.
    always_ff @(posedge clk_100) begin
        if (rst) begin
            r_req  <= 1'b0;
            r_data <= '0;
        end else if (i_flush) begin
            r_req  <= 1'b0;
        end else if (i_load) begin
            r_req  <= 1'b1;
            r_data <= i_load_data;
        end else if (r_req && i_ready) begin
            r_req  <= 1'b0;
        end
    end

    assign o_req  = r_req;
    assign o_data = r_data;

endmodule
`default_nettype wire

// File: rtl/frame_writer.sv
`default_nettype none
// ============================================================================
// Module   : frame_writer -- drains the camera pixel FIFO into a double-buffered
//            frame store and publishes the last complete buffer
// Revision : 1.0
// ============================================================================
module frame_writer
    import fw_pkg::*;
#(
    parameter int H_RES     = 640,
    parameter int V_RES     = 480,
    parameter int ADDR_W    = 20,
    parameter int BURST_LEN = 8,
    parameter int COUNT_W   = 10
) (
    input  logic               clk_100,
    input  logic               rst,
    input  logic [15:0]        fifo_dout,
    input  logic [COUNT_W-1:0] fifo_count,
    output logic               fifo_rd_en,
    input  logic               frame_sync,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [15:0]        mem_wdata,
    input  logic               mem_ready,
    output logic               disp_buf,
    output logic               frame_done,
    output logic               frame_err,
    output logic [15:0]        drop_cnt
);

    localparam int unsigned       c_frame_pix = fw_frame_pix(H_RES, V_RES);
    localparam logic [ADDR_W-2:0] c_last_idx  = (ADDR_W-1)'(c_frame_pix - 1);

    fw_state_t         r_state;
    logic              r_wr_buf;
    logic              r_disp_buf;
    logic [ADDR_W-2:0] r_pix_idx;
    logic [9:0]        r_beat;
    logic              r_fifo_rd_en;
    logic              r_frame_done;
    logic              r_frame_err;
    logic [15:0]       r_drop_cnt;

    int unsigned       w_need;
    logic              w_count_ok;
    logic              w_abort;
    logic              w_accept;
    logic              w_last;
    logic              w_load;

    assign w_need     = fw_need(BURST_LEN, c_frame_pix, 32'(r_pix_idx));
    assign w_count_ok = 32'(fifo_count) >= w_need;
    assign w_abort    = frame_sync && (r_state != IDLE);
    assign w_accept   = (r_state == WRITE) && mem_req && mem_ready;
    assign w_last     = (r_pix_idx == c_last_idx);
    assign w_load     = (r_state == FETCH) && !frame_sync;

    fw_beat_reg #(
        .DATA_W (16)
    ) u_beat_reg (
        .clk_100     (clk_100),
        .rst         (rst),
        .i_load      (w_load),
        .i_load_data (fifo_dout),
        .i_flush     (w_abort),
        .i_ready     (mem_ready),
        .o_req       (mem_req),
        .o_data      (mem_wdata)
    );

    always_ff @(posedge clk_100) begin
        if (rst) begin
            r_state      <= IDLE;
            r_wr_buf     <= 1'b0;
            r_disp_buf   <= 1'b1;
            r_pix_idx    <= '0;
            r_beat       <= '0;
            r_fifo_rd_en <= 1'b0;
            r_frame_done <= 1'b0;
            r_frame_err  <= 1'b0;
            r_drop_cnt   <= '0;
        end else begin
            r_fifo_rd_en <= 1'b0;
            r_frame_done <= 1'b0;
            r_frame_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (frame_sync) begin
                        r_pix_idx <= '0;
                        r_state   <= WAIT;
                    end else if (fifo_count != '0 && !r_fifo_rd_en) begin
                        // Unsynchronised pixels are thrown away one at a time.
                        r_fifo_rd_en <= 1'b1;
                        if (r_drop_cnt != 16'hFFFF) begin
                            r_drop_cnt <= r_drop_cnt + 16'd1;
                        end
                    end
                end
                WAIT: begin
                    if (frame_sync) begin
                        r_frame_err <= 1'b1;
                        r_pix_idx   <= '0;
                    end else if (w_count_ok) begin
                        r_beat       <= 10'(w_need);
                        r_fifo_rd_en <= 1'b1;
                        r_state      <= POP;
                    end
                end
                POP, FETCH: begin
                    if (frame_sync) begin
                        r_frame_err <= 1'b1;
                        r_pix_idx   <= '0;
                        r_state     <= WAIT;
                    end else begin
                        r_state <= (r_state == POP) ? FETCH : WRITE;
                    end
                end
                WRITE: begin
                    if (w_accept && w_last) begin
                        // A sync landing on the final beat starts the next frame directly.
                        r_frame_done <= 1'b1;
                        r_disp_buf   <= r_wr_buf;
                        r_wr_buf     <= ~r_wr_buf;
                        r_pix_idx    <= '0;
                        r_state      <= frame_sync ? WAIT : IDLE;
                    end else if (frame_sync) begin
                        r_frame_err <= 1'b1;
                        r_pix_idx   <= '0;
                        r_state     <= WAIT;
                    end else if (w_accept) begin
                        r_pix_idx <= r_pix_idx + 1'b1;
                        r_beat    <= r_beat - 10'd1;
                        if (r_beat == 10'd1) begin
                            r_state <= WAIT;
                        end else begin
                            r_fifo_rd_en <= 1'b1;
                            r_state      <= POP;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign fifo_rd_en = r_fifo_rd_en;
    assign mem_addr   = {r_wr_buf, r_pix_idx};
    assign disp_buf   = r_disp_buf;
    assign frame_done = r_frame_done;
    assign frame_err  = r_frame_err;
    assign drop_cnt   = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_frame_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_frame_writer -- randomized self-checking bench for frame_writer
// Revision : 1.0
// ============================================================================
module tb_frame_writer;

    localparam int H_RES     = 4;
    localparam int V_RES     = 2;
    localparam int ADDR_W    = 20;
    localparam int BURST_LEN = 3;
    localparam int COUNT_W   = 10;
    localparam int FP        = H_RES * V_RES;
    localparam logic [ADDR_W-2:0] c_idx2 = 2;

    logic               clk_100 = 1'b0;
    logic               rst = 1'b1;
    logic [15:0]        fifo_dout = '0;
    logic [COUNT_W-1:0] fifo_count = '0;
    logic               fifo_rd_en;
    logic               frame_sync = 1'b0;
    logic               mem_req;
    logic [ADDR_W-1:0]  mem_addr;
    logic [15:0]        mem_wdata;
    logic               mem_ready = 1'b1;
    logic               disp_buf;
    logic               frame_done;
    logic               frame_err;
    logic [15:0]        drop_cnt;

    frame_writer #(
        .H_RES(H_RES), .V_RES(V_RES), .ADDR_W(ADDR_W),
        .BURST_LEN(BURST_LEN), .COUNT_W(COUNT_W)
    ) dut (
        .clk_100(clk_100), .rst(rst), .fifo_dout(fifo_dout), .fifo_count(fifo_count),
        .fifo_rd_en(fifo_rd_en), .frame_sync(frame_sync), .mem_req(mem_req),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
        .disp_buf(disp_buf), .frame_done(frame_done), .frame_err(frame_err),
        .drop_cnt(drop_cnt)
    );

    always #5 clk_100 = ~clk_100;

    logic [15:0]       fifo_q[$];
    logic [15:0]       push_q[$];
    logic [15:0]       exp_q[$];
    logic [ADDR_W-1:0] obs_addr[$];
    logic [15:0]       obs_data[$];

    int n_total = 0, n_bad = 0;
    int pops = 0, empty_pops = 0, req_cycles = 0, done_cnt = 0, err_cnt = 0, hold_viol = 0;
    int ready_mode = 0, stall_left = 0;
    logic exp_wr_buf = 1'b0, exp_disp = 1'b1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // FIFO model: pop lands on dout next cycle, pushes trickle in from push_q.
    always @(posedge clk_100) begin
        if (rst) begin
            fifo_q.delete();
            fifo_count <= '0;
        end else begin
            if (fifo_rd_en) begin
                pops++;
                if (fifo_q.size() == 0) empty_pops++;
                else fifo_dout <= fifo_q.pop_front();
            end
            if (push_q.size() > 0 && $urandom_range(0, 2) != 0) fifo_q.push_back(push_q.pop_front());
            fifo_count <= COUNT_W'(fifo_q.size());
        end
    end

    logic              p_stall = 1'b0;
    logic [ADDR_W-1:0] p_addr = '0;
    logic [15:0]       p_data = '0;
    always @(posedge clk_100) begin
        if (!rst) begin
            if (mem_req) req_cycles++;
            if (frame_done) done_cnt++;
            if (frame_err) err_cnt++;
            if (p_stall && (!mem_req || mem_addr != p_addr || mem_wdata != p_data)) hold_viol++;
            if (mem_req && mem_ready) begin
                obs_addr.push_back(mem_addr);
                obs_data.push_back(mem_wdata);
            end
            p_stall = mem_req && !mem_ready && !frame_sync;
            p_addr  = mem_addr;
            p_data  = mem_wdata;
        end else begin
            p_stall = 1'b0;
        end
    end

    always @(negedge clk_100) begin
        case (ready_mode)
            0: mem_ready = 1'b1;
            1: mem_ready = ($urandom_range(0, 2) != 0);
            2: begin
                if (stall_left > 0 && mem_req && mem_addr[ADDR_W-2:0] == c_idx2) begin
                    mem_ready = 1'b0;
                    stall_left--;
                end else begin
                    mem_ready = 1'b1;
                end
            end
            default: mem_ready = 1'b0;
        endcase
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk_100);
    endtask

    task automatic pulse_sync();
        frame_sync = 1'b1;
        tick(1);
        frame_sync = 1'b0;
    endtask

    task automatic queue_words(input int n);
        for (int i = 0; i < n; i++) begin
            logic [15:0] w;
            w = 16'($urandom);
            push_q.push_back(w);
            exp_q.push_back(w);
        end
    endtask

    task automatic start_frame(input int mode);
        obs_addr.delete();
        obs_data.delete();
        exp_q.delete();
        ready_mode = mode;
    endtask

    task automatic wait_done(input int target, input string tag);
        int n;
        n = 0;
        while (done_cnt < target && n < 500) begin
            tick(1);
            n++;
        end
        tick(3);
        check_eq({tag, "_done"}, done_cnt, target);
    endtask

    // Completed frame: pixel i at {buffer, i}, then the buffers trade places.
    task automatic check_frame(input string tag);
        check_eq({tag, "_nwr"}, obs_addr.size(), FP);
        for (int i = 0; i < FP && i < obs_addr.size(); i++) begin
            check_eq({tag, "_addr"}, obs_addr[i], {exp_wr_buf, (ADDR_W-1)'(i)});
            check_eq({tag, "_data"}, obs_data[i], exp_q[i]);
        end
        exp_disp   = exp_wr_buf;
        exp_wr_buf = ~exp_wr_buf;
        check_eq({tag, "_disp"}, disp_buf, exp_disp);
        check_eq({tag, "_next_addr"}, mem_addr, {exp_wr_buf, (ADDR_W-1)'(0)});
    endtask

    task automatic clean_frame(input string tag, input int mode, input bit fixed);
        int d0, p0, n;
        start_frame(mode);
        d0 = done_cnt;
        p0 = pops;
        pulse_sync();
        if (fixed) begin
            for (int i = 0; i < FP; i++) begin
                push_q.push_back(16'(i + 1));
                exp_q.push_back(16'(i + 1));
            end
        end else begin
            queue_words(FP);
        end
        if (mode == 2) begin
            n = 0;
            while (stall_left > 5 && n < 300) begin
                tick(1);
                n++;
            end
            check_eq({tag, "_stall_req"}, mem_req, 1);
            check_eq({tag, "_stall_addr"}, mem_addr, {exp_wr_buf, c_idx2});
            check_eq({tag, "_stall_nopop"}, fifo_rd_en, 0);
        end
        wait_done(d0 + 1, tag);
        check_eq({tag, "_pops"}, pops - p0, FP);
        check_frame(tag);
    endtask

    initial begin
        int d0, e0, p0, n;
        tick(3);
        rst = 1'b0;
        check_eq("rst_req", mem_req, 0);
        check_eq("rst_rd_en", fifo_rd_en, 0);
        check_eq("rst_addr", mem_addr, 0);
        check_eq("rst_wdata", mem_wdata, 0);
        check_eq("rst_disp", disp_buf, 1);
        check_eq("rst_drop", drop_cnt, 0);
        check_eq("rst_flags", {frame_done, frame_err}, 0);

        // Words arriving before any frame_sync are dropped.
        p0 = pops;
        queue_words(5);
        tick(40);
        check_eq("drop_cnt", drop_cnt, 5);
        check_eq("drop_pops", pops - p0, 5);
        check_eq("drop_fifo_empty", fifo_q.size(), 0);
        check_eq("drop_no_req", req_cycles, 0);

        clean_frame("frame_a", 0, 1'b1);
        clean_frame("frame_b", 1, 1'b0);
        stall_left = 10;
        clean_frame("frame_stall", 2, 1'b0);
        check_eq("stall_used", stall_left, 0);

        // Abort after five pixels; the restart reuses the same buffer.
        start_frame(0);
        d0 = done_cnt;
        e0 = err_cnt;
        pulse_sync();
        queue_words(FP);
        n = 0;
        while (obs_addr.size() < 5 && n < 300) begin
            tick(1);
            n++;
        end
        check_eq("abort_reach5", obs_addr.size() >= 5, 1);
        pulse_sync();
        exp_q.delete();
        foreach (fifo_q[i]) exp_q.push_back(fifo_q[i]);
        foreach (push_q[i]) exp_q.push_back(push_q[i]);
        obs_addr.delete();
        obs_data.delete();
        tick(2);
        check_eq("abort_err", err_cnt - e0, 1);
        check_eq("abort_no_done", done_cnt, d0);
        check_eq("abort_disp", disp_buf, exp_disp);
        queue_words(FP - exp_q.size());
        wait_done(d0 + 1, "abort_restart");
        check_eq("abort_err_once", err_cnt - e0, 1);
        check_eq("abort_restart_nwr", obs_addr.size(), FP);
        check_frame("abort_restart");

        // Too few words for the first burst: no pop until the rest arrive.
        start_frame(1);
        d0 = done_cnt;
        p0 = pops;
        pulse_sync();
        queue_words(2);
        tick(20);
        check_eq("short_no_pop", pops - p0, 0);
        check_eq("short_no_wr", obs_addr.size(), 0);
        queue_words(FP - 2);
        wait_done(d0 + 1, "short");
        check_eq("short_pops", pops - p0, FP);
        check_frame("short");

        check_eq("drop_kept", drop_cnt, 5);
        check_eq("no_empty_pop", empty_pops, 0);
        check_eq("hold_stable", hold_viol, 0);

        // Reset mid-burst with the memory refusing the beat.
        start_frame(3);
        pulse_sync();
        queue_words(FP);
        n = 0;
        while (!mem_req && n < 100) begin
            tick(1);
            n++;
        end
        check_eq("midrst_req_before", mem_req, 1);
        rst = 1'b1;
        push_q.delete();
        tick(1);
        check_eq("midrst_req", mem_req, 0);
        check_eq("midrst_addr", mem_addr, 0);
        check_eq("midrst_disp", disp_buf, 1);
        check_eq("midrst_drop", drop_cnt, 0);
        rst = 1'b0;
        ready_mode = 0;
        tick(2);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
